adsr_mc: RTL and testbench
==========================

ADSR_MC -- requirements
Module: adsr_mc

Interface
REQ-001 Parameter NBIT_DATA, default 6: envelope level width; MAX = 2^NBIT_DATA-1.
REQ-002 Parameter NBIT_IDX, default 4: width of time-index inputs.
REQ-003 Parameter MAX_IDX, default 14: largest honoured time index; larger inputs saturate to MAX_IDX.
REQ-004 Parameter NCH, default 4: number of independent envelope channels.
REQ-005 Parameter NBIT_CNT, default 24: step-prescaler counter width.
REQ-006 Parameter STEP_BASE, default 190: prescaler threshold at index 0.
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 rstn  in  1  reset, asynchronous, active-low.
REQ-009 gate  in  NCH  per-channel note-on level (1 = key held).
REQ-010 trig  in  NCH  per-channel single-cycle retrigger pulse.
REQ-011 legato  in  1  0 = attack restarts from 0; 1 = attack continues from current level.
REQ-012 a_idx, d_idx, r_idx  in  NBIT_IDX each  attack/decay/release time index, shared by all channels.
REQ-013 s_level  in  NBIT_DATA  sustain level, shared.
REQ-014 dout  out  NCH*NBIT_DATA  channel k level at bits [k*NBIT_DATA +: NBIT_DATA].
REQ-015 active  out  NCH  1 when channel k is not IDLE.
REQ-016 done  out  NCH  one-cycle pulse when channel k goes RELEASE -> IDLE.

Function
REQ-017 Each channel SHALL run an independent FSM: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-018 Prescaler threshold for index i SHALL be THR(i) = (STEP_BASE << i) | (2^i - 1), truncated to NBIT_CNT bits; a tick occurs in the cycle cnt == THR, then cnt returns to 0 (tick period THR+1 cycles).
REQ-019 Index used: a_idx in ATTACK, d_idx in DECAY, r_idx in RELEASE; prescaler held at 0 in IDLE and SUSTAIN and cleared on every state change.
REQ-020 IDLE: level 0; gate=1 -> ATTACK next edge.
REQ-021 ATTACK: tick with level<MAX -> level+1; tick with level==MAX -> DECAY; gate=0 -> RELEASE (level held).
REQ-022 DECAY: level<=s_level -> SUSTAIN (checked every cycle, takes priority over tick); else tick -> level-1; gate=0 -> RELEASE.
REQ-023 SUSTAIN: level SHALL load s_level every cycle (tracks live changes); gate=0 -> RELEASE.
REQ-024 RELEASE: starts from current level; tick with level>0 -> level-1; level==0 -> IDLE with done pulse; gate=1 -> ATTACK.
REQ-025 Entry to ATTACK from RELEASE or via trig: level cleared to 0 when legato=0, kept when legato=1.
REQ-026 trig[k]=1 with gate[k]=1 SHALL force ATTACK from any state; trig with gate=0 SHALL be ignored.
REQ-027 Priority per cycle: gate=0 release > trig > state-internal transition > tick.
REQ-028 Level SHALL never wrap: saturate at MAX in ATTACK, at 0 in DECAY/RELEASE.
REQ-029 dout, active, done SHALL be registered; a transition is visible on outputs the edge after its cause.
REQ-030 Time-index changes SHALL take effect immediately; prescaler is not cleared (cnt>THR counts up and wraps at 2^NBIT_CNT).

Reset
REQ-031 rstn low SHALL asynchronously set all channels to IDLE, level 0, prescaler 0, dout=0, active=0, done=0.
REQ-032 Reset mid-envelope SHALL discard state; after release the channel waits for gate=1.

Structure
REQ-033 Shared package adsr_pkg: state encoding constants (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4), STEP_BASE default, THR function.
REQ-034 One sub-module adsr_ch (single-channel FSM, prescaler, level), instantiated NCH times by generate; top holds index saturation and output packing.

Verification (bench parameters NBIT_DATA=4, STEP_BASE=2, NCH=2, all idx=0 -> tick every 3 cycles)
REQ-035 gate0 high, s_level=8 -> dout0 ramps 0..15 one step per 3 cycles, DECAY after 16th tick, SUSTAIN at 8, channel 1 stays 0/inactive.
REQ-036 r_idx=1 (THR=5), gate0 low in SUSTAIN at 8 -> dout0 decrements every 6 cycles, IDLE after 8 ticks, done0 one cycle, active0 low.
REQ-037 gate low during ATTACK at level 5 -> RELEASE from 5, reaches 0, IDLE.
REQ-038 RELEASE at level 6, gate high: legato=0 -> ATTACK from 0; legato=1 -> ATTACK from 6.
REQ-039 SUSTAIN at 8, trig0 pulse with gate0=1 -> ATTACK; s_level changed to 3 in SUSTAIN -> dout0=3 next edge.
REQ-040 a_idx=15 -> behaves as idx 14; rstn low mid-DECAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared definitions for the multi-channel ADSR envelope generator.
// Holds the per-channel state encoding, the default prescaler base and
// the prescaler threshold function used by every channel.
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

  localparam int unsigned STEP_BASE_DEF = 190;

  // Threshold for time index sh: base shifted up with the vacated low bits
  // filled with ones. Callers truncate to their counter width.
  function automatic logic [63:0] thr_calc(input int unsigned base,
                                           input int unsigned sh);
    return (64'(base) << sh) | ((64'd1 << sh) - 64'd1);
  endfunction

endpackage

// File: rtl/adsr_ch.sv
// Single ADSR envelope channel: state machine, step prescaler and level.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   gate, trig, legato   note-on level, retrigger pulse, attack-continue mode
//   a_idx, d_idx, r_idx  already-saturated time indices
//   s_level              sustain level
//   level                registered envelope level
//   active               registered, high whenever the channel is not idle
//   done                 registered one-cycle pulse on release -> idle
module adsr_ch
  import adsr_pkg::*;
#(
  parameter int unsigned NBIT_DATA = 6,
  parameter int unsigned NBIT_IDX  = 4,
  parameter int unsigned NBIT_CNT  = 24,
  parameter int unsigned STEP_BASE = STEP_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 gate,
  input  logic                 trig,
  input  logic                 legato,
  input  logic [NBIT_IDX-1:0]  a_idx,
  input  logic [NBIT_IDX-1:0]  d_idx,
  input  logic [NBIT_IDX-1:0]  r_idx,
  input  logic [NBIT_DATA-1:0] s_level,
  output logic [NBIT_DATA-1:0] level,
  output logic                 active,
  output logic                 done
);

  localparam logic [NBIT_DATA-1:0] LVL_MAX = '1;

  adsr_state_t          state, state_nxt;
  logic [NBIT_DATA-1:0] level_q, level_nxt;
  logic [NBIT_CNT-1:0]  cnt_q, cnt_nxt, thr;
  logic [NBIT_IDX-1:0]  idx_cur;
  logic                 tick;
  logic                 restart;
  logic                 active_q, done_q;

  // Prescaler threshold follows the live index of the current phase.
  always_comb begin
    case (state)
      ST_ATTACK: idx_cur = a_idx;
      ST_DECAY:  idx_cur = d_idx;
      default:   idx_cur = r_idx;
    endcase
    thr  = NBIT_CNT'(thr_calc(STEP_BASE, 32'(idx_cur)));
    tick = (state == ST_ATTACK || state == ST_DECAY || state == ST_RELEASE) &&
           (cnt_q == thr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      level_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      level_q  <= level_nxt;
      cnt_q    <= cnt_nxt;
      active_q <= (state_nxt != ST_IDLE);
      done_q   <= (state == ST_RELEASE) && (state_nxt == ST_IDLE);
    end
  end

  // restart marks an attack entry governed by legato (trig, or re-gate
  // during release); it also covers attack -> attack retriggers.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    if (!gate && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
      state_nxt = ST_RELEASE;
    end else if (gate && trig) begin
      state_nxt = ST_ATTACK;
      restart   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gate) state_nxt = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (tick && level_q == LVL_MAX) state_nxt = ST_DECAY;
        end
        ST_DECAY: begin
          if (level_q <= s_level) state_nxt = ST_SUSTAIN;
        end
        ST_SUSTAIN: ;
        ST_RELEASE: begin
          if (gate) begin
            state_nxt = ST_ATTACK;
            restart   = 1'b1;
          end else if (level_q == '0) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Level only moves while the phase is unchanged; every phase change holds it
  // except a restart, where legato decides.
  always_comb begin
    level_nxt = level_q;
    cnt_nxt   = cnt_q + NBIT_CNT'(1);
    if (restart) begin
      level_nxt = legato ? level_q : '0;
    end else if (state_nxt == state) begin
      case (state)
        ST_ATTACK: begin
          if (tick && level_q != LVL_MAX) level_nxt = level_q + NBIT_DATA'(1);
        end
        ST_DECAY, ST_RELEASE: begin
          if (tick && level_q != '0) level_nxt = level_q - NBIT_DATA'(1);
        end
        ST_SUSTAIN: level_nxt = s_level;
        default: ;
      endcase
    end
    if (restart || state_nxt != state || state == ST_IDLE ||
        state == ST_SUSTAIN || tick) begin
      cnt_nxt = '0;
    end
  end

  assign level  = level_q;
  assign active = active_q;
  assign done   = done_q;

endmodule

// File: rtl/adsr_mc.sv
// Multi-channel ADSR envelope generator.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   gate, trig [NCH]     per-channel note-on level and retrigger pulse
//   legato               0: attack restarts at 0, 1: attack continues
//   a_idx, d_idx, r_idx  shared time indices, saturated to MAX_IDX here
//   s_level              shared sustain level
//   dout                 channel k level at [k*NBIT_DATA +: NBIT_DATA]
//   active, done [NCH]   per-channel busy flag and end-of-release pulse
module adsr_mc
  import adsr_pkg::*;
#(
  parameter int unsigned NBIT_DATA = 6,
  parameter int unsigned NBIT_IDX  = 4,
  parameter int unsigned MAX_IDX   = 14,
  parameter int unsigned NCH       = 4,
  parameter int unsigned NBIT_CNT  = 24,
  parameter int unsigned STEP_BASE = STEP_BASE_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NCH-1:0]           gate,
  input  logic [NCH-1:0]           trig,
  input  logic                     legato,
  input  logic [NBIT_IDX-1:0]      a_idx,
  input  logic [NBIT_IDX-1:0]      d_idx,
  input  logic [NBIT_IDX-1:0]      r_idx,
  input  logic [NBIT_DATA-1:0]     s_level,
  output logic [NCH*NBIT_DATA-1:0] dout,
  output logic [NCH-1:0]           active,
  output logic [NCH-1:0]           done
);

  localparam logic [NBIT_IDX-1:0] IDX_LIM = NBIT_IDX'(MAX_IDX);

  logic [NBIT_IDX-1:0] a_sat, d_sat, r_sat;

  always_comb begin
    a_sat = (a_idx > IDX_LIM) ? IDX_LIM : a_idx;
    d_sat = (d_idx > IDX_LIM) ? IDX_LIM : d_idx;
    r_sat = (r_idx > IDX_LIM) ? IDX_LIM : r_idx;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    adsr_ch #(
      .NBIT_DATA (NBIT_DATA),
      .NBIT_IDX  (NBIT_IDX),
      .NBIT_CNT  (NBIT_CNT),
      .STEP_BASE (STEP_BASE)
    ) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .gate    (gate[k]),
      .trig    (trig[k]),
      .legato  (legato),
      .a_idx   (a_sat),
      .d_idx   (d_sat),
      .r_idx   (r_sat),
      .s_level (s_level),
      .level   (dout[k*NBIT_DATA +: NBIT_DATA]),
      .active  (active[k]),
      .done    (done[k])
    );
  end

endmodule

// File: tb/tb_adsr_mc.sv
// Self-checking bench for adsr_mc (NBIT_DATA=4, STEP_BASE=2, NCH=2).
module tb_adsr_mc;

  localparam int NBD  = 4;
  localparam int NCH  = 2;
  localparam int NBI  = 4;
  localparam int NBC  = 24;
  localparam int SB   = 2;
  localparam int MAXI = 14;
  localparam int LMAX = 15;
  localparam int VW   = NCH*NBD + 2*NCH;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic [NCH-1:0] gate = '0;
  logic [NCH-1:0] trig = '0;
  logic           legato = 1'b0;
  logic [NBI-1:0] a_idx = '0, d_idx = '0, r_idx = '0;
  logic [NBD-1:0] s_level = '0;
  logic [NCH*NBD-1:0] dout;
  logic [NCH-1:0] active;
  logic [NCH-1:0] done;

  int total = 0;
  int bad   = 0;

  // Reference model: phase names, integer level, prescaler count.
  string          m_ph  [NCH];
  int             m_lvl [NCH];
  longint         m_cnt [NCH];
  logic [NCH-1:0] m_done;

  adsr_mc #(
    .NBIT_DATA (NBD),
    .NBIT_IDX  (NBI),
    .MAX_IDX   (MAXI),
    .NCH       (NCH),
    .NBIT_CNT  (NBC),
    .STEP_BASE (SB)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .gate    (gate),
    .trig    (trig),
    .legato  (legato),
    .a_idx   (a_idx),
    .d_idx   (d_idx),
    .r_idx   (r_idx),
    .s_level (s_level),
    .dout    (dout),
    .active  (active),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic longint thr_of(input int i);
    int j;
    longint p;
    j = (i > MAXI) ? MAXI : i;
    p = longint'(1) << j;
    return (longint'(SB) * p + p - 1) % (longint'(1) << NBC);
  endfunction

  task automatic model_step(input int k);
    string  ph = m_ph[k];
    int     lv = m_lvl[k];
    int     idx;
    longint t;
    bit     tk;
    string  nph;
    int     nlv;
    bit     rs = 1'b0;
    bit     dn = 1'b0;
    idx = (ph == "attack") ? int'(a_idx) : (ph == "decay") ? int'(d_idx) : int'(r_idx);
    t   = thr_of(idx);
    tk  = (ph == "attack" || ph == "decay" || ph == "release") && (m_cnt[k] == t);
    nph = ph;
    nlv = lv;
    if ((ph == "attack" || ph == "decay" || ph == "sustain") && !gate[k]) begin
      nph = "release";
    end else if (gate[k] && trig[k]) begin
      nph = "attack"; rs = 1'b1;
      if (!legato) nlv = 0;
    end else if (ph == "idle") begin
      if (gate[k]) nph = "attack";
    end else if (ph == "attack") begin
      if (tk) begin
        if (lv < LMAX) nlv = lv + 1;
        else nph = "decay";
      end
    end else if (ph == "decay") begin
      if (lv <= int'(s_level)) nph = "sustain";
      else if (tk) nlv = (lv > 0) ? lv - 1 : 0;
    end else if (ph == "sustain") begin
      nlv = int'(s_level);
    end else begin
      if (gate[k]) begin
        nph = "attack";
        if (!legato) nlv = 0;
      end else if (lv == 0) begin
        nph = "idle"; dn = 1'b1;
      end else if (tk) begin
        nlv = lv - 1;
      end
    end
    if (nph != ph || rs || nph == "idle" || nph == "sustain" || tk) m_cnt[k] = 0;
    else m_cnt[k] = (m_cnt[k] + 1) % (longint'(1) << NBC);
    m_ph[k]   = nph;
    m_lvl[k]  = nlv;
    m_done[k] = dn;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NCH; k++) begin
        m_ph[k] = "idle"; m_lvl[k] = 0; m_cnt[k] = 0; m_done[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) model_step(k);
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [NCH*NBD-1:0] d;
    logic [NCH-1:0]     a;
    for (int k = 0; k < NCH; k++) begin
      d[k*NBD +: NBD] = NBD'(m_lvl[k]);
      a[k] = (m_ph[k] != "idle");
    end
    return {d, a, m_done};
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if ({dout, active, done} !== '0) begin
      bad++; $display("FAIL reset_async: got %h want 0", {dout, active, done});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({dout, active, done} !== '0) begin
      bad++; $display("FAIL reset_release: got %h want 0", {dout, active, done});
    end
  endtask

  task automatic test_ramp();
    s_level = 4'd8;
    gate    = 2'b01;
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      if (n <= 46) begin
        total++;
        if (dout[3:0] !== 4'((n - 1) / 3)) begin
          bad++; $display("FAIL ramp_level n=%0d: got %0d want %0d", n, dout[3:0], (n - 1) / 3);
        end
      end
      if (n == 52 || n == 70) begin
        total++;
        if (dout[3:0] !== ((n == 52) ? 4'd14 : 4'd8)) begin
          bad++; $display("FAIL decay_level n=%0d: got %0d", n, dout[3:0]);
        end
      end
      total++;
      if ({dout[7:4], active[1], done[1]} !== 6'b0) begin
        bad++; $display("FAIL ch1_idle n=%0d: got %h want 0", n, {dout[7:4], active[1], done[1]});
      end
    end
    total++;
    if ({dout[3:0], active} !== {4'd8, 2'b01}) begin
      bad++; $display("FAIL sustain_8: got %h want %h", {dout[3:0], active}, {4'd8, 2'b01});
    end
  endtask

  task automatic test_release();
    r_idx = 4'd1;
    gate  = 2'b00;
    for (int n = 1; n <= 51; n++) begin
      @(negedge clk);
      if (n <= 49) begin
        total++;
        if ({dout[3:0], done} !== {4'(8 - (n - 1) / 6), 2'b00}) begin
          bad++; $display("FAIL release_level n=%0d: got %h want %h", n,
                          {dout[3:0], done}, {4'(8 - (n - 1) / 6), 2'b00});
        end
      end
      if (n == 50) begin
        total++;
        if ({done, active, dout} !== {2'b01, 2'b00, 8'h00}) begin
          bad++; $display("FAIL release_done: got %h want %h", {done, active, dout}, {2'b01, 2'b00, 8'h00});
        end
      end
      if (n == 51) begin
        total++;
        if (done !== 2'b00) begin
          bad++; $display("FAIL done_one_cycle: got %b want 00", done);
        end
      end
    end
    r_idx = 4'd0;
  endtask

  task automatic test_attack_release();
    bit found = 1'b0;
    bit idle  = 1'b0;
    int seen  = 0;
    gate = 2'b01;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      total++;
      if ({dout, active, done} !== exp_vec()) begin
        bad++; $display("FAIL ar_model: got %h want %h", {dout, active, done}, exp_vec());
      end
      if (dout[3:0] == 4'd5) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL ar_reach5: got %0d want 5 (timeout)", dout[3:0]);
    end
    gate = 2'b00;
    @(negedge clk);
    total++;
    if ({dout[3:0], active[0]} !== {4'd5, 1'b1}) begin
      bad++; $display("FAIL ar_release_start: got %h want %h", {dout[3:0], active[0]}, {4'd5, 1'b1});
    end
    for (int n = 0; n < 40 && !idle; n++) begin
      @(negedge clk);
      total++;
      if ({dout, active, done} !== exp_vec()) begin
        bad++; $display("FAIL ar_model: got %h want %h", {dout, active, done}, exp_vec());
      end
      if (done[0]) seen++;
      if (!active[0]) idle = 1'b1;
    end
    total++;
    if (!idle || seen != 1) begin
      bad++; $display("FAIL ar_idle: got idle=%0d done_pulses=%0d want idle=1 done_pulses=1", idle, seen);
    end
  endtask

  task automatic test_legato();
    bit idle = 1'b0;
    s_level = 4'd6;
    gate    = 2'b01;
    repeat (85) @(negedge clk);
    total++;
    if (dout[3:0] !== 4'd6) begin
      bad++; $display("FAIL leg_sustain6: got %0d want 6", dout[3:0]);
    end
    gate = 2'b00;
    @(negedge clk);
    total++;
    if (dout[3:0] !== 4'd6) begin
      bad++; $display("FAIL leg_release6: got %0d want 6", dout[3:0]);
    end
    gate = 2'b01; legato = 1'b0;
    @(negedge clk);
    total++;
    if (dout[3:0] !== 4'd0) begin
      bad++; $display("FAIL legato0_entry: got %0d want 0", dout[3:0]);
    end
    repeat (3) @(negedge clk);
    total++;
    if (dout[3:0] !== 4'd1) begin
      bad++; $display("FAIL legato0_attack: got %0d want 1", dout[3:0]);
    end
    gate = 2'b00;
    for (int n = 0; n < 20 && !idle; n++) begin
      @(negedge clk);
      if (!active[0]) idle = 1'b1;
    end
    total++;
    if (!idle) begin
      bad++; $display("FAIL leg_idle: got active=%b want 0 (timeout)", active[0]);
    end
    gate = 2'b01;
    repeat (85) @(negedge clk);
    gate = 2'b00;
    @(negedge clk);
    gate = 2'b01; legato = 1'b1;
    @(negedge clk);
    total++;
    if (dout[3:0] !== 4'd6) begin
      bad++; $display("FAIL legato1_entry: got %0d want 6", dout[3:0]);
    end
    repeat (3) @(negedge clk);
    total++;
    if (dout[3:0] !== 4'd7) begin
      bad++; $display("FAIL legato1_attack: got %0d want 7", dout[3:0]);
    end
    legato = 1'b0;
  endtask

  task automatic test_trig_sustain();
    s_level = 4'd8;
    repeat (60) @(negedge clk);
    total++;
    if (dout[3:0] !== 4'd8) begin
      bad++; $display("FAIL trig_pre_sustain: got %0d want 8", dout[3:0]);
    end
    s_level = 4'd3;
    @(negedge clk);
    total++;
    if (dout[3:0] !== 4'd3) begin
      bad++; $display("FAIL sustain_track: got %0d want 3", dout[3:0]);
    end
    trig = 2'b11;
    @(negedge clk);
    trig = 2'b00;
    total++;
    if ({dout, active} !== {8'h00, 2'b01}) begin
      bad++; $display("FAIL trig_entry: got %h want %h", {dout, active}, {8'h00, 2'b01});
    end
    repeat (3) @(negedge clk);
    total++;
    if ({dout, active} !== {8'h01, 2'b01}) begin
      bad++; $display("FAIL trig_attack: got %h want %h", {dout, active}, {8'h01, 2'b01});
    end
  endtask

  task automatic test_reset_mid();
    bit idle = 1'b0;
    gate = 2'b00;
    for (int n = 0; n < 20 && !idle; n++) begin
      @(negedge clk);
      if (active == 2'b00) idle = 1'b1;
    end
    total++;
    if (!idle) begin
      bad++; $display("FAIL rm_idle: got active=%b want 00 (timeout)", active);
    end
    s_level = 4'd2;
    gate    = 2'b01;
    repeat (55) @(negedge clk);
    total++;
    if ({dout[3:0], active} !== {4'd13, 2'b01}) begin
      bad++; $display("FAIL rm_decay: got %h want %h", {dout[3:0], active}, {4'd13, 2'b01});
    end
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({dout, active, done} !== '0) begin
      bad++; $display("FAIL reset_mid_decay: got %h want 0", {dout, active, done});
    end
    gate = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({dout, active, done} !== '0) begin
      bad++; $display("FAIL reset_wait_gate: got %h want 0", {dout, active, done});
    end
    gate = 2'b01;
    repeat (2) @(negedge clk);
    total++;
    if ({dout, active} !== {8'h00, 2'b01}) begin
      bad++; $display("FAIL reset_regate: got %h want %h", {dout, active}, {8'h00, 2'b01});
    end
  endtask

  task automatic test_random();
    bit quiet;
    int v;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      total++;
      if ({dout, active, done} !== exp_vec()) begin
        bad++; $display("FAIL random_model cyc=%0d: got %h want %h", i, {dout, active, done}, exp_vec());
      end
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(19) == 0) gate[k] = ~gate[k];
        trig[k] = ($urandom_range(29) == 0);
      end
      if ($urandom_range(49) == 0) legato  = 1'($urandom_range(1));
      if ($urandom_range(39) == 0) s_level = 4'($urandom_range(15));
      // Shrinking an index mid-phase can strand the count above the new
      // threshold for 2^24 cycles, so only allow it when nothing is counting.
      quiet = 1'b1;
      for (int k = 0; k < NCH; k++)
        if (m_ph[k] == "attack" || m_ph[k] == "decay" || m_ph[k] == "release") quiet = 1'b0;
      if ($urandom_range(99) == 0) begin
        v = $urandom_range(2); if (v >= int'(a_idx) || quiet) a_idx = 4'(v);
        v = $urandom_range(2); if (v >= int'(d_idx) || quiet) d_idx = 4'(v);
        v = $urandom_range(2); if (v >= int'(r_idx) || quiet) r_idx = 4'(v);
      end
    end
    trig = 2'b00;
  endtask

  task automatic test_sat();
    bit idle = 1'b0;
    gate = 2'b00;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      if (active == 2'b00) idle = 1'b1;
    end
    total++;
    if (!idle) begin
      bad++; $display("FAIL sat_idle: got active=%b want 00 (timeout)", active);
    end
    a_idx = 4'd15; d_idx = 4'd0; r_idx = 4'd0; legato = 1'b0;
    gate  = 2'b01;
    for (int n = 1; n <= 49153; n++) begin
      @(negedge clk);
      if (n == 49152 || n == 49153) begin
        total++;
        if (dout[3:0] !== ((n == 49152) ? 4'd0 : 4'd1)) begin
          bad++; $display("FAIL idx_saturate n=%0d: got %0d want %0d", n, dout[3:0], n - 49152);
        end
        total++;
        if ({dout, active, done} !== exp_vec()) begin
          bad++; $display("FAIL sat_model n=%0d: got %h want %h", n, {dout, active, done}, exp_vec());
        end
      end
    end
    gate = 2'b00;
  endtask

  initial begin
    #1 rstn = 1'b0;
    test_reset();
    test_ramp();
    test_release();
    test_attack_release();
    test_legato();
    test_trig_sustain();
    test_reset_mid();
    test_random();
    test_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
